// File: rtl/pcounter_pipe.sv
// pcounter_pipe: pipelined stream incrementer/decrementer.
//
// Applies one operation per accepted beat (INC/DEC by a programmable step,
// PASS, CLR) with wrap or saturate. The add/subtract is carry-split into
// STAGES slices, one slice per register stage, so a wide WIDTH still meets
// timing. The channel tag rides alongside the data through every stage.
// All state changes on the falling edge of clk.
//
// Ports:
//   clk, rst                 clock (falling-edge active), sync active-high reset
//   in_valid / in_ready      input handshake
//   in_ch                    channel tag (passed through unchanged)
//   in_data, in_step         operand and step magnitude (step zero-extended)
//   in_op                    00 INC, 01 DEC, 10 PASS, 11 CLR
//   in_sat                   1 = saturate, 0 = wrap
//   out_valid / out_ready    output handshake
//   out_ch, out_data         tag and result
//   out_ovf                  carry (INC) or borrow (DEC) out of the full width
module pcounter_pipe #(
  parameter int WIDTH  = 40,
  parameter int STEP_W = 8,
  parameter int NCH    = 4,
  parameter int STAGES = 2,
  localparam int CH_W  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STEP_W-1:0] in_step,
  input  logic [1:0]        in_op,
  input  logic              in_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_ovf
);

  // Slice width; the last slice may be narrower, and for some WIDTH/STAGES
  // combinations trailing stages get an empty slice and only forward carry.
  localparam int SW = (WIDTH + STAGES - 1) / STAGES;

  // Whole pipeline moves together; a stall freezes every stage.
  logic adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SW;
    localparam int HI = ((gi + 1) * SW > WIDTH) ? WIDTH : (gi + 1) * SW;

    // Inputs to this stage (from ports for stage 0, else previous stage).
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] step_in;
    logic             dec_in;
    logic             sat_in;
    logic             cy_in;
    logic             vld_in;
    logic [CH_W-1:0]  ch_in;

    logic [WIDTH-1:0] data_d;
    logic             cy_d;
    logic [WIDTH-1:0] res_d;

    logic [WIDTH-1:0] data_q;
    logic             cy_q;
    logic             vld_q;
    logic [CH_W-1:0]  ch_q;

    if (gi == 0) begin : g_src
      // PASS and CLR are folded into an INC of zero, so they can never
      // produce a carry and therefore ignore in_sat naturally.
      assign data_in = (in_op == 2'b11) ? '0 : in_data;
      assign step_in = in_op[1] ? '0 : WIDTH'(in_step);
      assign dec_in  = (in_op == 2'b01);
      assign sat_in  = in_sat;
      assign cy_in   = 1'b0;
      assign vld_in  = in_valid && in_ready;
      assign ch_in   = in_ch;
    end else begin : g_chain
      assign data_in = g_stage[gi-1].data_q;
      assign step_in = g_stage[gi-1].g_fwd.step_q;
      assign dec_in  = g_stage[gi-1].g_fwd.dec_q;
      assign sat_in  = g_stage[gi-1].g_fwd.sat_q;
      assign cy_in   = g_stage[gi-1].cy_q;
      assign vld_in  = g_stage[gi-1].vld_q;
      assign ch_in   = g_stage[gi-1].ch_q;
    end

    if (HI > LO) begin : g_add
      localparam int SL = HI - LO;
      // One extra bit on top catches carry-out, or for subtraction the
      // sign of the difference, which is exactly the borrow-out.
      logic [SL:0] sum;
      always_comb begin
        if (dec_in) begin
          sum = {1'b0, SL'(data_in >> LO)} - {1'b0, SL'(step_in >> LO)}
                - (SL + 1)'(cy_in);
        end else begin
          sum = {1'b0, SL'(data_in >> LO)} + {1'b0, SL'(step_in >> LO)}
                + (SL + 1)'(cy_in);
        end
        data_d        = data_in;
        data_d[HI-1:LO] = sum[SL-1:0];
        cy_d          = sum[SL];
      end
    end else begin : g_empty
      always_comb begin
        data_d = data_in;
        cy_d   = cy_in;
      end
    end

    if (gi == STAGES - 1) begin : g_clamp
      // Saturation needs the final carry/borrow, so it lives in the last stage.
      assign res_d = (sat_in && cy_d) ? (dec_in ? '0 : '1) : data_d;
    end else begin : g_mid
      assign res_d = data_d;
    end

    always_ff @(negedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        ch_q   <= '0;
        cy_q   <= 1'b0;
      end else if (adv) begin
        vld_q  <= vld_in;
        data_q <= res_d;
        ch_q   <= ch_in;
        cy_q   <= cy_d;
      end
    end

    // Step and op controls are only needed by later slices.
    if (gi < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] step_q;
      logic             dec_q;
      logic             sat_q;
      always_ff @(negedge clk) begin
        if (rst) begin
          step_q <= '0;
          dec_q  <= 1'b0;
          sat_q  <= 1'b0;
        end else if (adv) begin
          step_q <= step_in;
          dec_q  <= dec_in;
          sat_q  <= sat_in;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign out_data  = g_stage[STAGES-1].data_q;
  assign out_ch    = g_stage[STAGES-1].ch_q;
  assign out_ovf   = g_stage[STAGES-1].cy_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

endmodule
